// File: rtl/apb_rr_master.sv
// Round-robin APB master: arbitrates NREQ local requesters onto one APB completer,
// runs SETUP/ACCESS with wait-state tolerance and a timeout, and returns the response.
module apb_rr_master #(
    parameter int NREQ    = 2,
    parameter int AW      = 32,
    parameter int DW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic               pclk,
    input  logic               presetn,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    done,
    output logic [DW-1:0]      rsp_rdata,
    output logic               rsp_err,
    output logic               busy,
    output logic [AW-1:0]      paddr,
    output logic               pwrite,
    output logic [DW-1:0]      pwdata,
    output logic               psel,
    output logic               penable,
    input  logic [DW-1:0]      prdata,
    input  logic               pready,
    input  logic               pslverr
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TO_EN = (TIMEOUT > 0);
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t          state;
    logic [PW-1:0]   last;
    logic [PW-1:0]   grant;
    logic [CW-1:0]   wait_cnt;

    logic [NREQ-1:0] eligible;
    logic            win_valid;
    logic [PW-1:0]   win_idx;
    int              idx;
    logic            timeout_hit;

    // Search starts just after the last winner, so the previous grantee ranks lowest.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        eligible  = req & ~done;
        win_valid = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!win_valid && eligible[idx]) begin
                win_valid = 1'b1;
                win_idx   = PW'(idx);
            end
        end
    end

    assign timeout_hit = TO_EN && !pready && (wait_cnt == TO_LAST);

    // NOTE: asynchronous active-low reset; every register (no memories here) gets a reset value.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state     <= IDLE;
            last      <= PW'(NREQ - 1);
            grant     <= '0;
            wait_cnt  <= '0;
            done      <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments for all state; the later done[grant] overrides this default.
            done <= '0;
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        grant  <= win_idx;
                        paddr  <= req_addr[int'(win_idx)*AW +: AW];
                        pwrite <= req_write[win_idx];
                        pwdata <= req_wdata[int'(win_idx)*DW +: DW];
                        psel   <= 1'b1;
                        busy   <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready || timeout_hit) begin
                        done[grant] <= 1'b1;
                        rsp_rdata   <= (pready && !pwrite) ? prdata : '0;
                        rsp_err     <= pready ? pslverr : 1'b1;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        busy        <= 1'b0;
                        last        <= grant;
                        wait_cnt    <= '0;
                        state       <= IDLE;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
